data_ram_arbiter: RTL and testbench
===================================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
- REQ-001 SHALL have parameter ADDR_WIDTH, default 15, meaning RAM word-address width.
- REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; byte-enable width is DATA_WIDTH/8.
- REQ-003 SHALL have parameter MAX_WAIT, default 3, meaning consecutive port1 denials before port1 is forced; legal range 1..15.
- REQ-004 SHALL have one clock, port clk (input, 1), and a synchronous active-low reset, port rst_n (input, 1).
- REQ-005 SHALL have, for p in {0,1}, the following requester ports:
  - portp_req_i (input, 1): access request.
  - portp_gnt_o (output, 1): grant, same cycle as the request.
  - portp_rvalid_o (output, 1): response valid.
  - portp_addr_i (input, ADDR_WIDTH): address.
  - portp_we_i (input, 1): write enable.
  - portp_be_i (input, DATA_WIDTH/8): byte enables.
  - portp_wdata_i (input, DATA_WIDTH): write data.
  - portp_rdata_o (output, DATA_WIDTH): read data.
- REQ-006 SHALL have the following RAM-side ports:
  - ram_en_o (output, 1): RAM enable.
  - ram_addr_o (output, ADDR_WIDTH): RAM address.
  - ram_we_o (output, 1): RAM write enable.
  - ram_be_o (output, DATA_WIDTH/8): RAM byte enables.
  - ram_wdata_o (output, DATA_WIDTH): RAM write data.
  - ram_rdata_i (input, DATA_WIDTH): RAM read data, valid one cycle after an enabled access.
- REQ-007 SHALL have status output starve_o (output, 1), high while the FSM is in state P1_FORCE.

Function
- REQ-008 SHALL implement a 2-state FSM:
  - P0_PRIO: port0 (external bus) has priority.
  - P1_FORCE: port1 (core) has priority.
- REQ-009 SHALL keep a wait counter wait_cnt of width 4, saturating at MAX_WAIT.
- REQ-010 SHALL, in P0_PRIO, grant port0 whenever port0_req_i=1, otherwise grant port1 if port1_req_i=1.
- REQ-011 SHALL, in P1_FORCE, grant port1 whenever port1_req_i=1, otherwise grant port0 if port0_req_i=1.
- REQ-012 SHALL assert at most one gnt per cycle; gnt is combinational from the current req and FSM state.
- REQ-013 SHALL, in P0_PRIO, update wait_cnt as follows:
  - both ports request (port0 granted): wait_cnt increments.
  - port1 is granted, or port1_req_i=0: wait_cnt clears to 0.
- REQ-014 SHALL move P0_PRIO -> P1_FORCE on the clock edge where the incremented wait_cnt equals MAX_WAIT.
- REQ-015 SHALL, in P1_FORCE, return to P0_PRIO on the next edge unconditionally (port1 granted, or port1 no longer requesting) and clear wait_cnt.
- REQ-016 SHALL drive ram_en_o = port0_gnt_o | port1_gnt_o, with ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o taken from the granted port.
- REQ-017 SHALL drive ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o to all zeros when no port is granted.
- REQ-018 SHALL register the owner of each granted access (reads and writes alike) and assert that owner's portp_rvalid_o for exactly one cycle, one cycle after its gnt.
- REQ-019 SHALL drive portp_rdata_o = ram_rdata_i when portp_rvalid_o=1, else all zeros.
- REQ-020 SHALL support back-to-back grants to alternating ports with no bubble:
  - the rvalid for access N and the gnt for access N+1 coincide.
  - each rvalid routes to its own owner.
- REQ-021 SHALL treat the write/read distinction only by passing we through; a write still produces a one-cycle rvalid with rdata equal to ram_rdata_i.
- REQ-022 SHALL, when MAX_WAIT=1, alternate grants 0,1,0,1 under continuous dual requests.

Reset
- REQ-023 SHALL, when rst_n=0 at a clock edge, set the FSM to P0_PRIO, wait_cnt=0, the registered owner to none, both rvalid=0 and starve_o=0.
- REQ-024 SHALL force both gnt outputs and ram_en_o to 0 combinationally while rst_n=0.
- REQ-025 SHALL, on reset asserted mid-operation, discard any pending read response: no rvalid appears after the reset edge.

Verification
- REQ-026 Only port1 requests, addr 0x10, we=0 -> port1_gnt_o=1 the same cycle; port1_rvalid_o=1 next cycle with port1_rdata_o=ram_rdata_i; port0 signals stay 0.
- REQ-027 MAX_WAIT=3, both ports request continuously -> grant sequence 0,0,0,1,0,0,0,1; starve_o high only in the cycles port1 is granted.
- REQ-028 Both ports request for 2 cycles, then port1 drops for 1 cycle, then both request again -> wait_cnt resets to 0; port1 is next granted only after 3 further port0 grants.
- REQ-029 Alternating single grants port0 write (be=4'hF, wdata=0xDEADBEEF) then port1 read of the same addr -> ram_we_o=1 then 0; port0_rvalid_o then port1_rvalid_o in consecutive cycles; port1_rdata_o=0xDEADBEEF.
- REQ-030 rst_n=0 in the cycle after a port0 grant -> port0_rvalid_o stays 0; after release, the FSM is in P0_PRIO and the first dual request grants port0.
- REQ-031 No requests -> ram_en_o=0; ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o all 0; all gnt and rvalid outputs 0.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: port0 (bus) normally wins,
// port1 (core) is forced through after MAX_WAIT consecutive denials.
module data_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    port0_req_i,
  output logic                    port0_gnt_o,
  output logic                    port0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   port0_addr_i,
  input  logic                    port0_we_i,
  input  logic [DATA_WIDTH/8-1:0] port0_be_i,
  input  logic [DATA_WIDTH-1:0]   port0_wdata_i,
  output logic [DATA_WIDTH-1:0]   port0_rdata_o,
  input  logic                    port1_req_i,
  output logic                    port1_gnt_o,
  output logic                    port1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   port1_addr_i,
  input  logic                    port1_we_i,
  input  logic [DATA_WIDTH/8-1:0] port1_be_i,
  input  logic [DATA_WIDTH-1:0]   port1_wdata_i,
  output logic [DATA_WIDTH-1:0]   port1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    starve_o
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic {P0_PRIO, P1_FORCE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      wait_cnt_reg, wait_cnt_next;
  logic [1:0]      req, gnt;
  logic [1:0]      rvalid_reg, rvalid;
  logic [DATA_WIDTH-1:0] rdata [2];

  assign req = {port1_req_i, port0_req_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= P0_PRIO;
      wait_cnt_reg <= 4'd0;
      rvalid_reg   <= 2'b00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      rvalid_reg   <= gnt;
    end
  end

  always_comb begin
    gnt           = 2'b00;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    if (rst_n) begin
      case (state_reg)
        P0_PRIO: begin
          if (req[0])      gnt = 2'b01;
          else if (req[1]) gnt = 2'b10;
          // Only a port1 denial caused by a competing port0 request counts as waiting.
          if (req[0] && req[1]) begin
            wait_cnt_next = (wait_cnt_reg >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_reg + 4'd1;
            if (wait_cnt_next == MAX_WAIT_C) state_next = P1_FORCE;
          end else begin
            wait_cnt_next = 4'd0;
          end
        end
        P1_FORCE: begin
          if (req[1])      gnt = 2'b10;
          else if (req[0]) gnt = 2'b01;
          state_next    = P0_PRIO;
          wait_cnt_next = 4'd0;
        end
        default: begin
          state_next    = P0_PRIO;
          wait_cnt_next = 4'd0;
        end
      endcase
    end
  end

  assign port0_gnt_o = gnt[0];
  assign port1_gnt_o = gnt[1];
  assign starve_o    = (state_reg == P1_FORCE);

  // gnt is one-hot or zero, so an AND-OR mux also yields zeros when idle.
  assign ram_en_o    = |gnt;
  assign ram_addr_o  = ({ADDR_WIDTH{gnt[0]}} & port0_addr_i) | ({ADDR_WIDTH{gnt[1]}} & port1_addr_i);
  assign ram_we_o    = (gnt[0] & port0_we_i) | (gnt[1] & port1_we_i);
  assign ram_be_o    = ({(DATA_WIDTH/8){gnt[0]}} & port0_be_i) | ({(DATA_WIDTH/8){gnt[1]}} & port1_be_i);
  assign ram_wdata_o = ({DATA_WIDTH{gnt[0]}} & port0_wdata_i) | ({DATA_WIDTH{gnt[1]}} & port1_wdata_i);

  // Responses are suppressed while reset is held so a pending read never surfaces.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign rvalid[gi] = rvalid_reg[gi] & rst_n;
      assign rdata[gi]  = rvalid[gi] ? ram_rdata_i : '0;
    end
  endgenerate

  assign port0_rvalid_o = rvalid[0];
  assign port1_rvalid_o = rvalid[1];
  assign port0_rdata_o  = rdata[0];
  assign port1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized + directed bench for data_ram_arbiter with a request-level reference
// model (denial counting, expected response queue) and a behavioural RAM.
module tb_data_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 3;

  logic          clk, rst_n;
  logic          port0_req, port0_gnt, port0_rvalid, port0_we;
  logic [AW-1:0] port0_addr;
  logic [BW-1:0] port0_be;
  logic [DW-1:0] port0_wdata, port0_rdata;
  logic          port1_req, port1_gnt, port1_rvalid, port1_we;
  logic [AW-1:0] port1_addr;
  logic [BW-1:0] port1_be;
  logic [DW-1:0] port1_wdata, port1_rdata;
  logic          ram_en, ram_we, starve;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  data_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .port0_req_i(port0_req), .port0_gnt_o(port0_gnt), .port0_rvalid_o(port0_rvalid),
    .port0_addr_i(port0_addr), .port0_we_i(port0_we), .port0_be_i(port0_be),
    .port0_wdata_i(port0_wdata), .port0_rdata_o(port0_rdata),
    .port1_req_i(port1_req), .port1_gnt_o(port1_gnt), .port1_rvalid_o(port1_rvalid),
    .port1_addr_i(port1_addr), .port1_we_i(port1_we), .port1_be_i(port1_be),
    .port1_wdata_i(port1_wdata), .port1_rdata_o(port1_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .starve_o(starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read returning pre-write contents.
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr[5:0]];
      if (ram_we)
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) ram_mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  int            denials;
  bit            pend0, pend1;
  logic [DW-1:0] pend_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r0, input bit r1,
                      input logic [5:0] a0, input logic [5:0] a1,
                      input bit w0, input bit w1,
                      input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit forced, e0, e1;
    logic [5:0]    ea;
    bit            ew;
    logic [BW-1:0] eb;
    logic [DW-1:0] ed;
    rst_n = !rst;
    port0_req = r0; port0_addr = {{(AW-6){1'b0}}, a0}; port0_we = w0; port0_be = b0; port0_wdata = d0;
    port1_req = r1; port1_addr = {{(AW-6){1'b0}}, a1}; port1_we = w1; port1_be = b1; port1_wdata = d1;
    @(negedge clk);
    forced = (denials >= MW);
    e0 = 0; e1 = 0;
    if (!rst) begin
      if (forced) begin e1 = r1; e0 = r0 && !r1; end
      else        begin e0 = r0; e1 = r1 && !r0; end
    end
    ea = e0 ? a0 : (e1 ? a1 : 6'd0);
    ew = e0 ? w0 : (e1 ? w1 : 1'b0);
    eb = e0 ? b0 : (e1 ? b1 : '0);
    ed = e0 ? d0 : (e1 ? d1 : '0);
    check_eq("gnt0", port0_gnt, e0);
    check_eq("gnt1", port1_gnt, e1);
    check_eq("ram_en", ram_en, e0 | e1);
    check_eq("ram_addr", ram_addr, ea);
    check_eq("ram_we", ram_we, ew);
    check_eq("ram_be", ram_be, eb);
    check_eq("ram_wdata", ram_wdata, ed);
    check_eq("starve", starve, forced);
    check_eq("rvalid0", port0_rvalid, pend0 && !rst);
    check_eq("rvalid1", port1_rvalid, pend1 && !rst);
    check_eq("rdata0", port0_rdata, (pend0 && !rst) ? pend_data : '0);
    check_eq("rdata1", port1_rdata, (pend1 && !rst) ? pend_data : '0);
    $display("cyc %0d rst=%0b req=%0b%0b gnt=%0b%0b addr=%0h we=%0b rv=%0b%0b starve=%0b",
             cycle, rst, r1, r0, port1_gnt, port0_gnt, ram_addr, ram_we,
             port1_rvalid, port0_rvalid, starve);
    @(posedge clk);
    #1;
    cycle++;
    if (rst) begin
      denials = 0; pend0 = 0; pend1 = 0;
    end else begin
      pend0 = e0; pend1 = e1;
      if (e0 || e1) begin
        pend_data = ref_mem[ea];
        if (ew)
          for (int b = 0; b < BW; b++)
            if (eb[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
      end
      if (forced)        denials = 0;
      else if (r0 && r1) denials++;
      else               denials = 0;
    end
  endtask

  task automatic idle(input bit rst);
    step(rst, 0, 0, 6'd0, 6'd0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic both(input logic [5:0] a0, input logic [5:0] a1);
    step(0, 1, 1, a0, a1, 0, 0, '1, '1, 32'h1111_0000, 32'h2222_0000);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    ram_rdata = '0;
    denials = 0; pend0 = 0; pend1 = 0; pend_data = '0;

    idle(1); idle(1);                        // reset state
    idle(0); idle(0);                        // no requests: all outputs zero
    step(0, 0, 1, 6'd0, 6'h10, 0, 0, '0, 4'hF, '0, '0);  // port1-only read
    idle(0);
    for (int i = 0; i < 8; i++) both(6'(i), 6'(i + 20));  // 0,0,0,1,0,0,0,1
    idle(0);
    both(6'd1, 6'd2); both(6'd1, 6'd2);      // starvation counter then broken
    step(0, 1, 0, 6'd3, 6'd0, 0, 0, '1, '0, '0, '0);
    for (int i = 0; i < 5; i++) both(6'd4, 6'd5);
    idle(0);
    step(0, 1, 0, 6'd5, 6'd0, 1, 0, 4'hF, '0, 32'hDEADBEEF, '0);  // write
    step(0, 0, 1, 6'd0, 6'd5, 0, 0, '0, 4'hF, '0, '0);           // read back
    idle(0);
    step(0, 1, 0, 6'd7, 6'd0, 0, 0, '1, '0, '0, '0);  // grant, then reset
    idle(1);
    both(6'd8, 6'd9);
    idle(0);

    for (int n = 0; n < 400; n++) begin
      bit rst;
      rst = ($urandom_range(0, 99) < 3);
      step(rst, ($urandom % 4) != 0, ($urandom % 3) != 0,
           6'($urandom % 64), 6'($urandom % 64),
           bit'($urandom % 2), bit'($urandom % 2),
           BW'($urandom), BW'($urandom), $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
